axis_pkt_sink: RTL and testbench

//  Receiving end of the 64-bit AXI-Stream packet interface: consumes the packets that packet sources emit.

---
 rtl/axis_sink_pkg.sv | 41 ++++
 rtl/axis_sink_bp_gen.sv | 45 ++++
 rtl/axis_pkt_sink.sv | 156 +++++++++++++++
 tb/tb_axis_pkt_sink.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sink_pkg.sv
// axis_sink_pkg: shared types, error-bit indices and helper functions for
// the axis_pkt_sink frame checker.
//   state_t         : frame FSM states (IDLE, PKT)
//   ERR_*           : bit positions inside pkt_err
//   keep_popcount   : number of set tkeep bits
//   keep_contiguous : tkeep is of the form 2^n-1 with n>=1
//   csum_add16      : 16-bit ones'-complement add with end-around carry
package axis_sink_pkg;

  typedef enum logic {IDLE, PKT} state_t;

  localparam int unsigned ERR_NONLAST_KEEP = 0;
  localparam int unsigned ERR_LAST_KEEP    = 1;
  localparam int unsigned ERR_USER_CHG     = 2;
  localparam int unsigned ERR_OVERSIZE     = 3;

  // Helpers take tkeep zero-extended to this width.
  localparam int unsigned KEEP_MAX_W = 32;

  function automatic logic [6:0] keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
    logic [6:0] n;
    n = '0;
    for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
      n = n + 7'(keep[i]);
    end
    return n;
  endfunction

  // Zero-extension keeps 2^n-1 patterns intact, so the wide test is exact.
  function automatic logic keep_contiguous(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
  endfunction

  // A single fold suffices: the folded value can never carry again.
  function automatic logic [15:0] csum_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/axis_sink_bp_gen.sv
// axis_sink_bp_gen: repeating ready pattern, RDY_ON cycles high then
// RDY_OFF cycles low. The pattern only advances while i_enable is high.
// RDY_OFF=0 keeps ready permanently high whenever enabled.
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset (restarts in ON phase, count 0)
//   i_enable : advance pattern / allow ready
//   o_ready  : pattern output, gated by enable and reset
module axis_sink_bp_gen #(
  parameter int RDY_ON  = 50,
  parameter int RDY_OFF = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_ready
);

  localparam int MAXC = (RDY_ON > RDY_OFF) ? RDY_ON : RDY_OFF;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic          r_on;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  always_comb begin
    w_last = r_on ? (r_cnt == CW'(RDY_ON - 1)) : (r_cnt == CW'(RDY_OFF - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_on  <= 1'b1;
      r_cnt <= '0;
    end else if (i_enable) begin
      if (w_last) begin
        r_cnt <= '0;
        if (RDY_OFF != 0) r_on <= ~r_on;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_ready = i_enable && r_on && !i_rst;

endmodule

// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI-Stream packet sink. Applies a ready pattern, checks
// tkeep/tlast/tuser framing and reports per-packet length, sideband, error
// flags and checksum, plus wrapping packet/error counters.
// Optional checksum: define AXIS_SINK_CSUM_EN; otherwise pkt_csum is 0.
//   apclk, apreset          : clock, asynchronous active-high reset
//   enable, stats_clr       : ready enable, synchronous counter clear
//   fromNet_axis_*          : incoming stream (tdata/tkeep/tuser/tlast/tvalid/tready)
//   pkt_done                : 1-cycle result strobe
//   pkt_len/user/err/csum   : held packet results
//   pkt_cnt, err_cnt        : completed packets, packets with errors
module axis_pkt_sink
  import axis_sink_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = 8,
  parameter int USER_W  = 64,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 32,
  parameter int MAX_LEN = 9000,
  parameter int RDY_ON  = 50,
  parameter int RDY_OFF = 10
) (
  input  logic              apclk,
  input  logic              apreset,
  input  logic              enable,
  input  logic              stats_clr,
  input  logic [DATA_W-1:0] fromNet_axis_tdata,
  input  logic [KEEP_W-1:0] fromNet_axis_tkeep,
  input  logic [USER_W-1:0] fromNet_axis_tuser,
  input  logic              fromNet_axis_tlast,
  input  logic              fromNet_axis_tvalid,
  output logic              fromNet_axis_tready,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [USER_W-1:0] pkt_user,
  output logic [3:0]        pkt_err,
  output logic [15:0]       pkt_csum,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  state_t            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len;
  logic [USER_W-1:0] r_user;
  logic [3:0]        r_err;

  logic              w_beat, w_first, w_finish;
  logic [6:0]        w_beat_bytes;
  logic [LEN_W:0]    w_len_sum;
  logic [LEN_W-1:0]  w_len_nxt;
  logic [3:0]        w_err_beat, w_err_nxt, w_err_final;

  axis_sink_bp_gen #(
    .RDY_ON  (RDY_ON),
    .RDY_OFF (RDY_OFF)
  ) u_bp_gen (
    .i_clk    (apclk),
    .i_rst    (apreset),
    .i_enable (enable),
    .o_ready  (fromNet_axis_tready)
  );

  assign w_beat = fromNet_axis_tvalid && fromNet_axis_tready;

  always_ff @(posedge apclk or posedge apreset) begin
    if (apreset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_beat) w_state_nxt = fromNet_axis_tlast ? IDLE : PKT;
  end

  always_comb begin
    w_first      = (r_state == IDLE);
    w_finish     = w_beat && fromNet_axis_tlast;
    w_beat_bytes = keep_popcount(KEEP_MAX_W'(fromNet_axis_tkeep));
    w_len_sum    = {1'b0, (w_first ? '0 : r_len)} + (LEN_W+1)'(w_beat_bytes);
    w_len_nxt    = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];

    w_err_beat = '0;
    w_err_beat[ERR_NONLAST_KEEP] = !fromNet_axis_tlast && (fromNet_axis_tkeep != '1);
    w_err_beat[ERR_LAST_KEEP]    = fromNet_axis_tlast &&
                                   !keep_contiguous(KEEP_MAX_W'(fromNet_axis_tkeep));
    w_err_beat[ERR_USER_CHG]     = !w_first && (fromNet_axis_tuser != r_user);
    w_err_nxt   = (w_first ? 4'b0000 : r_err) | w_err_beat;
    // Length only grows, so checking oversize once at the final beat is exact.
    w_err_final = w_err_nxt;
    w_err_final[ERR_OVERSIZE] = (w_len_nxt > LEN_W'(MAX_LEN));
  end

  always_ff @(posedge apclk or posedge apreset) begin
    if (apreset) begin
      r_len    <= '0;
      r_user   <= '0;
      r_err    <= '0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      pkt_user <= '0;
      pkt_err  <= '0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      pkt_done <= w_finish;
      if (w_beat) begin
        r_len <= w_len_nxt;
        r_err <= w_err_nxt;
        if (w_first) r_user <= fromNet_axis_tuser;
      end
      if (w_finish) begin
        pkt_len  <= w_len_nxt;
        pkt_user <= w_first ? fromNet_axis_tuser : r_user;
        pkt_err  <= w_err_final;
      end
      if (stats_clr) begin
        pkt_cnt <= '0;
        err_cnt <= '0;
      end else if (w_finish) begin
        pkt_cnt <= pkt_cnt + 1'b1;
        if (w_err_final != 4'b0000) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

`ifdef AXIS_SINK_CSUM_EN
  logic [15:0] r_csum, w_csum_beat, w_csum_nxt, w_word;

  // Words are byte-swapped lanes (network order), masked per byte by tkeep.
  always_comb begin
    w_csum_beat = '0;
    w_word      = '0;
    for (int unsigned i = 0; i < DATA_W/16; i++) begin
      w_word[15:8] = fromNet_axis_tkeep[2*i]   ? fromNet_axis_tdata[16*i +: 8]     : 8'h00;
      w_word[7:0]  = fromNet_axis_tkeep[2*i+1] ? fromNet_axis_tdata[16*i+8 +: 8]   : 8'h00;
      w_csum_beat  = csum_add16(w_csum_beat, w_word);
    end
    w_csum_nxt = csum_add16(w_first ? 16'h0000 : r_csum, w_csum_beat);
  end

  always_ff @(posedge apclk or posedge apreset) begin
    if (apreset) begin
      r_csum   <= '0;
      pkt_csum <= '0;
    end else begin
      if (w_beat)   r_csum   <= w_csum_nxt;
      if (w_finish) pkt_csum <= ~w_csum_nxt;
    end
  end
`else
  logic w_unused_tdata;
  assign w_unused_tdata = ^fromNet_axis_tdata;
  assign pkt_csum       = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_sink.sv
module tb_axis_pkt_sink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // DUT A: ready always high when enabled
  logic        a_en, a_clr, a_last, a_valid, a_tready, a_done;
  logic [63:0] a_data, a_user, a_puser;
  logic [7:0]  a_keep;
  logic [15:0] a_len, a_csum;
  logic [3:0]  a_err;
  logic [31:0] a_cnt, a_ecnt;
  // DUT B: 50 on / 10 off ready pattern
  logic        b_en, b_clr, b_last, b_valid, b_tready, b_done;
  logic [63:0] b_data, b_user, b_puser;
  logic [7:0]  b_keep;
  logic [15:0] b_len, b_csum;
  logic [3:0]  b_err;
  logic [31:0] b_cnt, b_ecnt;

  int n_checks = 0;
  int n_errors = 0;

  axis_pkt_sink #(.RDY_ON(50), .RDY_OFF(0)) u_dut (
    .apclk(clk), .apreset(rst), .enable(a_en), .stats_clr(a_clr),
    .fromNet_axis_tdata(a_data), .fromNet_axis_tkeep(a_keep),
    .fromNet_axis_tuser(a_user), .fromNet_axis_tlast(a_last),
    .fromNet_axis_tvalid(a_valid), .fromNet_axis_tready(a_tready),
    .pkt_done(a_done), .pkt_len(a_len), .pkt_user(a_puser), .pkt_err(a_err),
    .pkt_csum(a_csum), .pkt_cnt(a_cnt), .err_cnt(a_ecnt)
  );

  axis_pkt_sink #(.RDY_ON(50), .RDY_OFF(10)) u_dut_bp (
    .apclk(clk), .apreset(rst), .enable(b_en), .stats_clr(b_clr),
    .fromNet_axis_tdata(b_data), .fromNet_axis_tkeep(b_keep),
    .fromNet_axis_tuser(b_user), .fromNet_axis_tlast(b_last),
    .fromNet_axis_tvalid(b_valid), .fromNet_axis_tready(b_tready),
    .pkt_done(b_done), .pkt_len(b_len), .pkt_user(b_puser), .pkt_err(b_err),
    .pkt_csum(b_csum), .pkt_cnt(b_cnt), .err_cnt(b_ecnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic [63:0] u,
                      input logic l);
    int   n;
    logic acc;
    a_data = d; a_keep = k; a_user = u; a_last = l; a_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = a_tready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept", acc, 1'b1);
    a_valid = 1'b0;
  endtask

  task automatic chk_pkt(input string tag, input logic [15:0] len, input logic [3:0] err,
                         input logic [31:0] cnt, input logic [31:0] ecnt);
    check({tag, "_done"}, a_done, 1'b1);
    check({tag, "_len"},  a_len,  len);
    check({tag, "_err"},  a_err,  err);
    check({tag, "_cnt"},  a_cnt,  cnt);
    check({tag, "_ecnt"}, a_ecnt, ecnt);
  endtask

  logic [15:0] exp_cs_full, exp_cs_half, exp_cs_two;
  int          acc_b;

  initial begin
`ifdef AXIS_SINK_CSUM_EN
    exp_cs_full = 16'hF3EF;  // ~(0001+0203+0405+0607)
    exp_cs_half = 16'hFDFB;  // ~(0001+0203)
    exp_cs_two  = 16'hF1EB;  // ~(0C10+0204)
`else
    exp_cs_full = 16'h0000;
    exp_cs_half = 16'h0000;
    exp_cs_two  = 16'h0000;
`endif
    rst = 1'b1;
    a_en = 1'b1; a_clr = 1'b0; a_last = 1'b0; a_valid = 1'b0;
    a_data = '0; a_user = '0; a_keep = '0;
    b_en = 1'b0; b_clr = 1'b0; b_last = 1'b1; b_valid = 1'b0;
    b_data = '0; b_user = '0; b_keep = 8'hFF;
    #12;
    check("rst_tready", a_tready, 1'b0);
    check("rst_done",   a_done,   1'b0);
    check("rst_len",    a_len,    16'd0);
    check("rst_user",   a_puser,  64'd0);
    check("rst_err",    a_err,    4'd0);
    check("rst_csum",   a_csum,   16'd0);
    check("rst_cnt",    a_cnt,    32'd0);
    check("rst_ecnt",   a_ecnt,   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single beat, 4 bytes
    send(64'd0, 8'h0F, 64'hA5, 1'b1);
    chk_pkt("t1", 16'd4, 4'b0000, 32'd1, 32'd0);
    check("t1_user", a_puser, 64'hA5);
    tick(1);
    check("t1_pulse", a_done, 1'b0);
    check("t1_hold",  a_len,  16'd4);

    // 3-beat packet, then back-to-back single beats
    send(64'd0, 8'hFF, 64'd7, 1'b0);
    send(64'd0, 8'hFF, 64'd7, 1'b0);
    check("t2_mid_done", a_done, 1'b0);
    send(64'd0, 8'h03, 64'd7, 1'b1);
    chk_pkt("t2a", 16'd18, 4'b0000, 32'd2, 32'd0);
    send(64'd0, 8'hFF, 64'd8, 1'b1);
    chk_pkt("t2b", 16'd8, 4'b0000, 32'd3, 32'd0);
    send(64'd0, 8'h01, 64'd9, 1'b1);
    chk_pkt("t2c", 16'd1, 4'b0000, 32'd4, 32'd0);
    check("t2c_user", a_puser, 64'd9);
    tick(1);

    // partial keep on a non-last beat
    send(64'd0, 8'h7F, 64'd1, 1'b0);
    send(64'd0, 8'hFF, 64'd1, 1'b1);
    chk_pkt("t3", 16'd15, 4'b0001, 32'd5, 32'd1);

    // non-contiguous last keep; tuser change; empty last keep
    send(64'd0, 8'h05, 64'd2, 1'b1);
    chk_pkt("t4a", 16'd2, 4'b0010, 32'd6, 32'd2);
    send(64'd0, 8'hFF, 64'd3, 1'b0);
    send(64'd0, 8'h0F, 64'd4, 1'b1);
    chk_pkt("t4b", 16'd12, 4'b0100, 32'd7, 32'd3);
    check("t4b_user", a_puser, 64'd3);
    send(64'd0, 8'h00, 64'd5, 1'b1);
    chk_pkt("t4c", 16'd0, 4'b0010, 32'd8, 32'd4);

    // oversize boundary: 9000 bytes ok, 9008 flagged
    for (int i = 0; i < 1124; i++) send(64'd0, 8'hFF, 64'd0, 1'b0);
    send(64'd0, 8'hFF, 64'd0, 1'b1);
    chk_pkt("len9000", 16'd9000, 4'b0000, 32'd9, 32'd4);
    for (int i = 0; i < 1125; i++) send(64'd0, 8'hFF, 64'd0, 1'b0);
    send(64'd0, 8'hFF, 64'd0, 1'b1);
    chk_pkt("len9008", 16'd9008, 4'b1000, 32'd10, 32'd5);

    // stats_clr wins over a coincident finish
    a_clr = 1'b1;
    send(64'd0, 8'hFF, 64'd5, 1'b1);
    a_clr = 1'b0;
    chk_pkt("clr", 16'd8, 4'b0000, 32'd0, 32'd0);
    send(64'd0, 8'h05, 64'd6, 1'b1);
    chk_pkt("clr_after", 16'd2, 4'b0010, 32'd1, 32'd1);

    // enable drop mid-packet stalls but keeps state
    send(64'd0, 8'hFF, 64'd7, 1'b0);
    a_en = 1'b0;
    a_data = '0; a_keep = 8'hFF; a_user = 64'd7; a_last = 1'b1; a_valid = 1'b1;
    tick(1);
    check("en_tready", a_tready, 1'b0);
    tick(4);
    check("en_done", a_done, 1'b0);
    check("en_cnt",  a_cnt,  32'd1);
    a_valid = 1'b0;
    a_en = 1'b1;
    send(64'd0, 8'hFF, 64'd7, 1'b1);
    chk_pkt("en_resume", 16'd16, 4'b0000, 32'd2, 32'd1);

    // checksum
    send(64'h0706050403020100, 8'hFF, 64'd0, 1'b1);
    chk_pkt("cs1", 16'd8, 4'b0000, 32'd3, 32'd1);
    check("cs1_csum", a_csum, exp_cs_full);
    send(64'h0706050403020100, 8'h0F, 64'd0, 1'b1);
    check("cs2_csum", a_csum, exp_cs_half);
    send(64'h0706050403020100, 8'hFF, 64'd0, 1'b0);
    send(64'h0706050403020100, 8'h0F, 64'd0, 1'b1);
    check("cs3_len",  a_len,  16'd12);
    check("cs3_csum", a_csum, exp_cs_two);
    check("cs3_cnt",  a_cnt,  32'd5);

    // reset mid-packet drops the partial packet
    send(64'd0, 8'hFF, 64'd1, 1'b0);
    send(64'd0, 8'hFF, 64'd1, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_done",   a_done,   1'b0);
    check("arst_cnt",    a_cnt,    32'd0);
    check("arst_tready", a_tready, 1'b0);
    check("arst_len",    a_len,    16'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    check("arst_nodone", a_done, 1'b0);
    send(64'd0, 8'h03, 64'd2, 1'b1);
    chk_pkt("arst_new", 16'd2, 4'b0000, 32'd1, 32'd0);
    check("arst_user", a_puser, 64'd2);

    // ready pattern: 50 on / 10 off with tvalid held high
    b_en = 1'b1;
    b_valid = 1'b1;
    acc_b = 0;
    for (int k = 0; k < 400 && acc_b < 200; k++) begin
      @(negedge clk);
      check("bp_ready", b_tready, ((k % 60) < 50));
      if (b_tready) acc_b++;
      @(posedge clk);
      #1;
      if (acc_b == 200) b_valid = 1'b0;
    end
    b_valid = 1'b0;
    check("bp_accepted", acc_b, 200);
    tick(2);
    check("bp_cnt",  b_cnt,  32'd200);
    check("bp_ecnt", b_ecnt, 32'd0);
    check("bp_len",  b_len,  16'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
